sram_access_ctrl: RTL and testbench

- Clocked request/response front end for the 256x8 level-sensitive SRAM model.
- Accepts single read/write requests over valid/ready and drives the SRAM pins `address`, `data_in`, `read_write` and `chip_en` with a safe setup/access/hold sequence.
- Captures `data_out` into a held response.
- Provides a whole-array clear sweep used after power-up.

---
 rtl/sram_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// Request/response front end for a level-sensitive single-port SRAM.
// Every SRAM pin is registered; address, data and direction only move while chip_en is low,
// so a level-write SRAM never sees a glitching write. A clear sweep walks the whole array
// writing CLR_VALUE, reusing the same SETUP/ACCESS/HOLD sequence as a normal write.
module sram_access_ctrl #(
  parameter int unsigned      ADDR_W        = 8,
  parameter int unsigned      DATA_W        = 8,
  parameter int unsigned      ACCESS_CYCLES = 1,
  parameter logic [DATA_W-1:0] CLR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              rst,
  // Request channel
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  // Read response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  // Clear sweep control
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy,
  // SRAM pins
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              read_write,
  output logic              chip_en,
  input  logic [DATA_W-1:0] data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold,
    StResp
  } state_e;

  // Down-counter reload: the ACCESS state lasts AccLoad+1 cycles.
  localparam logic [3:0]      AccLoad  = 4'(ACCESS_CYCLES - 1);
  localparam int unsigned     NumLocs  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LastAddr = (ADDR_W + 1)'(NumLocs - 1);

  state_e              state_q, state_d;
  logic                clr_mode_q, clr_mode_d;
  logic [3:0]          acc_cnt_q, acc_cnt_d;
  logic [ADDR_W:0]     sweep_q, sweep_d;
  logic [ADDR_W:0]     sweep_inc;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   data_in_q, data_in_d;
  logic                read_write_q, read_write_d;
  logic                chip_en_q, chip_en_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                clr_done_q, clr_done_d;

  // A pending clear pre-empts any request presented in the same cycle.
  assign req_ready = (state_q == StIdle) && !clr_start && !rst;
  assign busy      = (state_q != StIdle);
  assign sweep_inc = sweep_q + 1'b1;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign clr_done   = clr_done_q;
  assign address    = address_q;
  assign data_in    = data_in_q;
  assign read_write = read_write_q;
  assign chip_en    = chip_en_q;

  // Next-state and next-pin decode for the access sequencer.
  always_comb begin
    state_d      = state_q;
    clr_mode_d   = clr_mode_q;
    acc_cnt_d    = acc_cnt_q;
    sweep_d      = sweep_q;
    address_d    = address_q;
    data_in_d    = data_in_q;
    read_write_d = read_write_q;
    chip_en_d    = chip_en_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    clr_done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          clr_mode_d   = 1'b1;
          sweep_d      = '0;
          address_d    = '0;
          data_in_d    = CLR_VALUE;
          read_write_d = 1'b1;
          state_d      = StSetup;
        end else if (req_valid && req_ready) begin
          clr_mode_d   = 1'b0;
          address_d    = req_addr;
          data_in_d    = req_wdata;
          read_write_d = req_write;
          state_d      = StSetup;
        end
      end
      StSetup: begin
        chip_en_d = 1'b1;
        acc_cnt_d = AccLoad;
        state_d   = StAccess;
      end
      StAccess: begin
        if (acc_cnt_q == 4'd0) begin
          chip_en_d = 1'b0;
          if (read_write_q) begin
            state_d = StHold;
          end else begin
            // data_out is sampled while chip_en is still high.
            rsp_rdata_d = data_out;
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
        end else begin
          acc_cnt_d = acc_cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (!clr_mode_q) begin
          state_d = StIdle;
        end else if (sweep_q == LastAddr) begin
          clr_mode_d = 1'b0;
          clr_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          // chip_en is low here, so advancing the address is safe.
          sweep_d   = sweep_inc;
          address_d = sweep_inc[ADDR_W-1:0];
          state_d   = StSetup;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered SRAM pins; reset drops any in-flight access or sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      clr_mode_q   <= 1'b0;
      acc_cnt_q    <= '0;
      sweep_q      <= '0;
      address_q    <= '0;
      data_in_q    <= '0;
      read_write_q <= 1'b0;
      chip_en_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_mode_q   <= clr_mode_d;
      acc_cnt_q    <= acc_cnt_d;
      sweep_q      <= sweep_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
      read_write_q <= read_write_d;
      chip_en_q    <= chip_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      clr_done_q   <= clr_done_d;
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (1 and 3 access cycles), each with a 256x8
// SRAM model. Read requests push their expected data into a scoreboard queue; a negedge
// monitor pops and compares on every response handshake and watches pin stability.
module tb_sram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid  [2];
  logic       req_ready  [2];
  logic       req_write  [2];
  logic [7:0] req_addr   [2];
  logic [7:0] req_wdata  [2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic [7:0] rsp_rdata  [2];
  logic       clr_start  [2];
  logic       clr_done   [2];
  logic       busy       [2];
  logic [7:0] address    [2];
  logic [7:0] data_in    [2];
  logic       read_write [2];
  logic       chip_en    [2];
  logic [7:0] data_out   [2];

  typedef struct packed {
    logic       dut;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_ent;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pin_viol  = 0;
  int rsp_viol  = 0;

  logic       prev_ce    [2];
  logic [7:0] prev_addr  [2];
  logic [7:0] prev_din   [2];
  logic       prev_rw    [2];
  logic       prev_valid [2];
  logic       prev_ready [2];
  logic [7:0] prev_rdata [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] mem [256];

    // Level-sensitive SRAM approximated on the clock; pins are stable while enabled.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
      end else if (chip_en[g] && read_write[g]) begin
        mem[address[g]] <= data_in[g];
      end
    end

    assign data_out[g] = (chip_en[g] && !read_write[g]) ? mem[address[g]] : 8'h00;

    sram_access_ctrl #(
      .ADDR_W       (8),
      .DATA_W       (8),
      .ACCESS_CYCLES((g == 0) ? 1 : 3),
      .CLR_VALUE    (8'h00)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .clr_start (clr_start[g]),
      .clr_done  (clr_done[g]),
      .busy      (busy[g]),
      .address   (address[g]),
      .data_in   (data_in[g]),
      .read_write(read_write[g]),
      .chip_en   (chip_en[g]),
      .data_out  (data_out[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor plus SRAM pin and response stability watch.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && (chip_en[d] || prev_ce[d]) &&
          (address[d] != prev_addr[d] || data_in[d] != prev_din[d] ||
           read_write[d] != prev_rw[d])) begin
        pin_viol++;
        $display("pin change while enabled on dut %0d at t=%0t", d, $time);
      end
      if (!rst && prev_valid[d] && !prev_ready[d] &&
          (!rsp_valid[d] || rsp_rdata[d] != prev_rdata[d])) begin
        rsp_viol++;
      end
      if (rsp_valid[d] && rsp_ready[d]) begin
        check("rsp_queue_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          mon_ent = exp_q.pop_front();
          check("rsp_dut", d, {31'd0, mon_ent.dut});
          check("rsp_rdata", {24'd0, rsp_rdata[d]}, {24'd0, mon_ent.data});
        end
      end
      prev_ce[d]    <= chip_en[d];
      prev_addr[d]  <= address[d];
      prev_din[d]   <= data_in[d];
      prev_rw[d]    <= read_write[d];
      prev_valid[d] <= rsp_valid[d];
      prev_ready[d] <= rsp_ready[d];
      prev_rdata[d] <= rsp_rdata[d];
    end
  end

  // Write with cycle-exact enable and ready timing for n access cycles.
  task automatic write_timed(input int d, input logic [7:0] a, input logic [7:0] v,
                             input int n);
    tick();
    req_write[d] = 1'b1;
    req_addr[d]  = a;
    req_wdata[d] = v;
    req_valid[d] = 1'b1;
    @(negedge clk);
    check("wr_accept_ready", req_ready[d], 1);
    for (int k = 1; k <= n + 3; k++) begin
      tick();
      req_valid[d] = 1'b0;
      @(negedge clk);
      check("wr_chip_en", chip_en[d], (k >= 2 && k <= n + 1) ? 1 : 0);
      if (k >= 2 && k <= n + 1) check("wr_address", address[d], a);
      if (k == 2) begin
        check("wr_data_in", data_in[d], v);
        check("wr_read_write", read_write[d], 1);
      end
      if (k >= n + 2) check("wr_req_ready", req_ready[d], (k == n + 3) ? 1 : 0);
    end
  endtask

  // Read with rsp_ready low for the first hold+1 valid cycles; data checked by the monitor.
  task automatic read_timed(input int d, input logic [7:0] a, input logic [7:0] e,
                            input int n, input int hold);
    exp_t ent;
    tick();
    req_write[d] = 1'b0;
    req_addr[d]  = a;
    req_wdata[d] = 8'h00;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b0;
    ent.dut  = (d == 1);
    ent.data = e;
    exp_q.push_back(ent);
    @(negedge clk);
    check("rd_accept_ready", req_ready[d], 1);
    for (int k = 1; k <= n + 2; k++) begin
      tick();
      req_valid[d] = 1'b0;
      @(negedge clk);
      check("rd_rsp_valid_timing", rsp_valid[d], (k == n + 2) ? 1 : 0);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      @(negedge clk);
    end
    check("rd_valid_held", rsp_valid[d], 1);
    tick();
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rd_valid_drop", rsp_valid[d], 0);
  endtask

  initial begin
    int busy_n;
    int done_n;
    int got;
    int stray;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 8'h00;
      req_wdata[d] = 8'h00;
      rsp_ready[d] = 1'b1;
      clr_start[d] = 1'b0;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 0);
      check("rst_chip_en", chip_en[d], 0);
      check("rst_busy", busy[d], 0);
      check("rst_rsp_valid", rsp_valid[d], 0);
      check("rst_outputs", {address[d], data_in[d], read_write[d], clr_done[d]}, 0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready[0], 1);

    // Basic write, then a stalled read of the same location.
    write_timed(0, 8'h10, 8'h3C, 1);
    read_timed(0, 8'h10, 8'h3C, 1, 4);

    // Clear sweep over a pre-written array.
    write_timed(0, 8'h00, 8'hA5, 1);
    write_timed(0, 8'hFF, 8'hA5, 1);
    tick();
    clr_start[0] = 1'b1;
    @(negedge clk);
    check("clr_req_ready_low", req_ready[0], 0);
    tick();
    clr_start[0] = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (busy[0]) busy_n++;
      if (clr_done[0]) done_n++;
      tick();
    end
    check("clr_busy_cycles", busy_n, 768);
    check("clr_done_cycles", done_n, 1);
    read_timed(0, 8'h00, 8'h00, 1, 0);
    read_timed(0, 8'hFF, 8'h00, 1, 0);

    // Simultaneous clear and request: request waits for the sweep.
    tick();
    clr_start[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 8'h20;
    req_wdata[0] = 8'h55;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("simul_ready_low", req_ready[0], 0);
    tick();
    clr_start[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 1000 && got == 0; c++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1;
      else tick();
    end
    check("simul_accept_seen", got, 1);
    check("simul_accept_at_done", clr_done[0], 1);
    tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();
    read_timed(0, 8'h20, 8'h55, 1, 0);

    // Reset during the ACCESS cycle of a write.
    tick();
    req_write[0] = 1'b1;
    req_addr[0]  = 8'h30;
    req_wdata[0] = 8'h99;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    check("rstmid_in_access", chip_en[0], 1);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rstmid_chip_en", chip_en[0], 0);
    check("rstmid_busy", busy[0], 0);
    check("rstmid_req_ready", req_ready[0], 0);
    check("rstmid_outputs", {address[0], data_in[0], read_write[0], rsp_valid[0]}, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_after", req_ready[0], 1);
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (rsp_valid[0] || clr_done[0]) stray++;
    end
    check("rstmid_no_stray", stray, 0);

    // Three-cycle access instance.
    write_timed(1, 8'h05, 8'h77, 3);
    read_timed(1, 8'h05, 8'h77, 3, 0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("pin_stability", pin_viol, 0);
    check("rsp_stability", rsp_viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
